// File: rtl/issue_scheduler.sv
// Decode-to-execute issue controller: per-register write scoreboard, shared MDU structural
// hazard, NOP bubble insertion, execute backpressure and flush handling.

package instruction;
    typedef struct packed {
        logic [6:0] funct7;
        logic [4:0] rs2_address;
        logic [4:0] rs1_address;
        logic [2:0] funct3;
        logic [4:0] rd_address;
        logic [6:0] opcode;
    } t;

    // addi x0, x0, 0
    localparam t NOP = '{funct7: 7'h00, rs2_address: 5'd0, rs1_address: 5'd0,
                         funct3: 3'd0, rd_address: 5'd0, opcode: 7'h13};
endpackage

module issue_scheduler #(
    parameter int LAT_W       = 3,
    parameter int MDU_CYCLES  = 8,
    parameter int STALL_CNT_W = 32
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   decode_valid,
    output logic                   decode_ready,
    input  instruction::t          decode_instruction,
    input  logic                   decode_uses_rs1,
    input  logic                   decode_uses_rs2,
    input  logic                   decode_writes_rd,
    input  logic [LAT_W-1:0]       decode_latency,
    input  logic                   decode_uses_mdu,
    input  logic                   execute_ready,
    input  logic                   flush,
    output logic                   issue_valid,
    output instruction::t          issue_instruction,
    output logic                   hazard_stall,
    output logic [STALL_CNT_W-1:0] stall_cycles
);
    logic [31:0][LAT_W-1:0]  sb;
    logic [7:0]              mdu_busy_reg;
    logic                    issue_valid_reg;
    instruction::t           issue_instruction_reg;
    logic [STALL_CNT_W-1:0]  stall_cycles_reg;

    logic [4:0] rs1;
    logic [4:0] rs2;
    logic [4:0] rd;
    logic       raw1;
    logic       raw2;
    logic       waw;
    logic       str;
    logic       hazard;
    logic       advance;
    logic       fire;
    logic       load;

    assign rs1 = decode_instruction.rs1_address;
    assign rs2 = decode_instruction.rs2_address;
    assign rd  = decode_instruction.rd_address;

    assign advance = execute_ready;
    assign raw1    = decode_uses_rs1 && (rs1 != 5'd0) && (sb[rs1] != '0);
    assign raw2    = decode_uses_rs2 && (rs2 != 5'd0) && (sb[rs2] != '0);
    // A later write may proceed once the older one lands no later than ours would.
    assign waw     = decode_writes_rd && (rd != 5'd0) && (sb[rd] > decode_latency);
    assign str     = decode_uses_mdu && (mdu_busy_reg != 8'd0);
    assign hazard  = raw1 | raw2 | waw | str;

    assign hazard_stall = decode_valid & ~flush & hazard;
    assign decode_ready = advance & ~flush & ~hazard;
    assign fire         = decode_valid & decode_ready;
    assign load         = fire & decode_writes_rd & (rd != 5'd0);

    assign sb[0] = '0;

    genvar gi;
    generate
        for (gi = 1; gi < 32; gi++) begin : g_sb
            logic [LAT_W-1:0] count_reg;

            always_ff @(posedge clock or posedge reset) begin
                if (reset) begin
                    count_reg <= '0;
                end else if (advance) begin
                    if (load && (rd == 5'(gi)))
                        count_reg <= decode_latency;
                    else if (count_reg != '0)
                        count_reg <= count_reg - 1'b1;
                end
            end

            assign sb[gi] = count_reg;
        end
    endgenerate

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            issue_instruction_reg <= instruction::NOP;
            issue_valid_reg       <= 1'b0;
            mdu_busy_reg          <= 8'd0;
        end else if (advance) begin
            issue_instruction_reg <= fire ? decode_instruction : instruction::NOP;
            issue_valid_reg       <= fire;
            if (fire && decode_uses_mdu)
                mdu_busy_reg <= 8'(MDU_CYCLES);
            else if (mdu_busy_reg != 8'd0)
                mdu_busy_reg <= mdu_busy_reg - 8'd1;
        end
    end

    // Counts stalled cycles even while execute holds the pipe.
    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            stall_cycles_reg <= '0;
        else if (hazard_stall)
            stall_cycles_reg <= stall_cycles_reg + STALL_CNT_W'(1);
    end

    assign issue_instruction = issue_instruction_reg;
    assign issue_valid       = issue_valid_reg;
    assign stall_cycles      = stall_cycles_reg;
endmodule

// File: tb/tb_issue_scheduler.sv
// Directed bench for issue_scheduler: RAW, WAW, x0, MDU, backpressure, flush and reset cases
// with hand-computed expectations.

module tb_issue_scheduler;
    logic          clock = 1'b0;
    logic          reset;
    logic          decode_valid;
    logic          decode_ready;
    instruction::t decode_instruction;
    logic          decode_uses_rs1;
    logic          decode_uses_rs2;
    logic          decode_writes_rd;
    logic [2:0]    decode_latency;
    logic          decode_uses_mdu;
    logic          execute_ready;
    logic          flush;
    logic          issue_valid;
    instruction::t issue_instruction;
    logic          hazard_stall;
    logic [31:0]   stall_cycles;

    int            n_checks = 0;
    int            n_fail   = 0;
    logic [31:0]   exp_stall;

    instruction::t lw5, add6, add5, sub7, addi0, add1, waw0, lw10, addi10, div8, mul9;

    issue_scheduler #(.LAT_W(3), .MDU_CYCLES(8), .STALL_CNT_W(32)) dut (
        .clock              (clock),
        .reset              (reset),
        .decode_valid       (decode_valid),
        .decode_ready       (decode_ready),
        .decode_instruction (decode_instruction),
        .decode_uses_rs1    (decode_uses_rs1),
        .decode_uses_rs2    (decode_uses_rs2),
        .decode_writes_rd   (decode_writes_rd),
        .decode_latency     (decode_latency),
        .decode_uses_mdu    (decode_uses_mdu),
        .execute_ready      (execute_ready),
        .flush              (flush),
        .issue_valid        (issue_valid),
        .issue_instruction  (issue_instruction),
        .hazard_stall       (hazard_stall),
        .stall_cycles       (stall_cycles)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end else begin
            $display("ok   %s: %0h", tag, got);
        end
    endtask

    function automatic instruction::t mk(input logic [6:0] opc, input logic [4:0] rd,
                                         input logic [4:0] rs1, input logic [4:0] rs2,
                                         input logic [6:0] f7);
        instruction::t i;
        i             = instruction::NOP;
        i.opcode      = opc;
        i.rd_address  = rd;
        i.rs1_address = rs1;
        i.rs2_address = rs2;
        i.funct7      = f7;
        return i;
    endfunction

    task automatic cyc();
        @(posedge clock);
        #1;
    endtask

    task automatic present(input instruction::t ins, input logic u1, input logic u2,
                           input logic wr, input logic [2:0] lat, input logic mdu);
        decode_valid       = 1'b1;
        decode_instruction = ins;
        decode_uses_rs1    = u1;
        decode_uses_rs2    = u2;
        decode_writes_rd   = wr;
        decode_latency     = lat;
        decode_uses_mdu    = mdu;
    endtask

    task automatic idle();
        decode_valid       = 1'b0;
        decode_instruction = instruction::NOP;
        decode_uses_rs1    = 1'b0;
        decode_uses_rs2    = 1'b0;
        decode_writes_rd   = 1'b0;
        decode_latency     = 3'd0;
        decode_uses_mdu    = 1'b0;
    endtask

    task automatic expect_issue(input string tag, input instruction::t ins, input logic v);
        check({tag, "_instr"}, 32'(ins === instruction::NOP ? issue_instruction : issue_instruction), 32'(ins));
        check({tag, "_valid"}, 32'(issue_valid), 32'(v));
    endtask

    initial begin
        int k;
        logic got;

        lw5    = mk(7'h03, 5'd5,  5'd1, 5'd0, 7'h00);
        add6   = mk(7'h33, 5'd6,  5'd5, 5'd1, 7'h00);
        add5   = mk(7'h33, 5'd5,  5'd1, 5'd2, 7'h00);
        sub7   = mk(7'h33, 5'd7,  5'd5, 5'd5, 7'h20);
        addi0  = mk(7'h13, 5'd0,  5'd3, 5'd0, 7'h05);
        add1   = mk(7'h33, 5'd1,  5'd0, 5'd0, 7'h00);
        waw0   = mk(7'h13, 5'd0,  5'd2, 5'd0, 7'h07);
        lw10   = mk(7'h03, 5'd10, 5'd1, 5'd0, 7'h00);
        addi10 = mk(7'h13, 5'd10, 5'd2, 5'd0, 7'h01);
        div8   = mk(7'h33, 5'd8,  5'd1, 5'd2, 7'h01);
        mul9   = mk(7'h33, 5'd9,  5'd3, 5'd4, 7'h01);

        idle();
        execute_ready = 1'b1;
        flush         = 1'b0;
        reset         = 1'b1;
        exp_stall     = 0;
        #1;
        expect_issue("reset", instruction::NOP, 1'b0);
        check("reset_stall_cycles", stall_cycles, 0);
        cyc();
        cyc();
        reset = 1'b0;
        check("reset_decode_ready", 32'(decode_ready), 1);

        // lw x5 (L=1) then dependent add: one bubble
        present(lw5, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        cyc();
        expect_issue("raw_lw", lw5, 1'b1);
        present(add6, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        #1;
        check("raw_hazard", 32'(hazard_stall), 1);
        check("raw_ready", 32'(decode_ready), 0);
        exp_stall++;
        cyc();
        expect_issue("raw_bubble", instruction::NOP, 1'b0);
        check("raw_hazard_clear", 32'(hazard_stall), 0);
        cyc();
        expect_issue("raw_add", add6, 1'b1);
        check("raw_stall_cycles", stall_cycles, exp_stall);

        // latency 0 producer: back to back
        present(add5, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc();
        expect_issue("fwd_add", add5, 1'b1);
        present(sub7, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        #1;
        check("fwd_hazard", 32'(hazard_stall), 0);
        cyc();
        expect_issue("fwd_sub", sub7, 1'b1);
        check("fwd_stall_cycles", stall_cycles, exp_stall);

        // x0 is never a hazard source or target
        present(addi0, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        cyc();
        expect_issue("x0_addi", addi0, 1'b1);
        present(add1, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        #1;
        check("x0_raw_hazard", 32'(hazard_stall), 0);
        cyc();
        expect_issue("x0_add", add1, 1'b1);
        present(waw0, 1'b1, 1'b0, 1'b1, 3'd0, 1'b0);
        #1;
        check("x0_waw_hazard", 32'(hazard_stall), 0);
        cyc();
        expect_issue("x0_waw", waw0, 1'b1);

        // WAW: sb=3 > 2 stalls once, sb=2 is not > 2
        present(lw10, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        cyc();
        present(addi10, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        #1;
        check("waw_hazard", 32'(hazard_stall), 1);
        exp_stall++;
        cyc();
        expect_issue("waw_bubble", instruction::NOP, 1'b0);
        check("waw_hazard_clear", 32'(hazard_stall), 0);
        cyc();
        expect_issue("waw_addi", addi10, 1'b1);

        // div then mul: MDU busy for 8 cycles
        present(div8, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        cyc();
        expect_issue("mdu_div", div8, 1'b1);
        present(mul9, 1'b1, 1'b1, 1'b1, 3'd0, 1'b1);
        #1;
        check("mdu_hazard", 32'(hazard_stall), 1);
        k   = 0;
        got = 1'b0;
        while (!got && k < 20) begin
            cyc();
            k++;
            if (issue_valid) got = 1'b1;
        end
        check("mdu_edges", 32'(k), 9);
        expect_issue("mdu_mul", mul9, 1'b1);
        exp_stall += 8;
        check("mdu_stall_cycles", stall_cycles, exp_stall);

        // execute backpressure freezes state, stall counter keeps counting
        present(lw5, 1'b1, 1'b0, 1'b1, 3'd1, 1'b0);
        cyc();
        present(add6, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        execute_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cyc();
            expect_issue($sformatf("freeze%0d", i), lw5, 1'b1);
            check($sformatf("freeze%0d_hazard", i), 32'(hazard_stall), 1);
            check($sformatf("freeze%0d_ready", i), 32'(decode_ready), 0);
        end
        exp_stall += 3;
        execute_ready = 1'b1;
        cyc();
        exp_stall++;
        expect_issue("freeze_bubble", instruction::NOP, 1'b0);
        cyc();
        expect_issue("freeze_add", add6, 1'b1);
        check("freeze_stall_cycles", stall_cycles, exp_stall);

        // flush during RAW stall: NOP issued, scoreboard keeps counting down
        present(lw5, 1'b1, 1'b0, 1'b1, 3'd2, 1'b0);
        cyc();
        present(add6, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        flush = 1'b1;
        #1;
        check("flush_hazard", 32'(hazard_stall), 0);
        check("flush_ready", 32'(decode_ready), 0);
        cyc();
        expect_issue("flush_nop", instruction::NOP, 1'b0);
        flush = 1'b0;
        #1;
        check("flush_after_hazard", 32'(hazard_stall), 1);
        exp_stall++;
        cyc();
        expect_issue("flush_bubble", instruction::NOP, 1'b0);
        cyc();
        expect_issue("flush_add", add6, 1'b1);
        check("flush_stall_cycles", stall_cycles, exp_stall);

        // asynchronous reset mid-stall
        present(lw5, 1'b1, 1'b0, 1'b1, 3'd3, 1'b0);
        cyc();
        present(add6, 1'b1, 1'b1, 1'b1, 3'd0, 1'b0);
        cyc();
        exp_stall++;
        check("rst_pre_stall_cycles", stall_cycles, exp_stall);
        reset = 1'b1;
        #1;
        expect_issue("rst_async", instruction::NOP, 1'b0);
        check("rst_stall_cycles", stall_cycles, 0);
        check("rst_hazard", 32'(hazard_stall), 0);
        #1;
        reset = 1'b0;
        #1;
        check("rst_ready", 32'(decode_ready), 1);
        cyc();
        expect_issue("rst_add", add6, 1'b1);
        check("rst_final_stall_cycles", stall_cycles, 0);
        idle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
